// File: rtl/uart_arbiter.sv
// uart_arbiter: round-robin arbiter sharing one UART register port between NUM_REQ bus masters.
// Optional BUSY watchdog is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [NUM_REQ-1:0]       i_req_request,
    input  logic [NUM_REQ-1:0]       i_req_rw,
    input  logic [NUM_REQ-1:0][1:0]  i_req_address,
    input  logic [NUM_REQ-1:0][31:0] i_req_wdata,
    input  logic [NUM_REQ-1:0]       i_req_lock,
    output logic [31:0]              o_req_rdata,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic                     o_uart_request,
    output logic                     o_uart_rw,
    output logic [1:0]               o_uart_address,
    output logic [31:0]              o_uart_wdata,
    input  logic [31:0]              i_uart_rdata,
    input  logic                     i_uart_ready,
    output logic                     o_timeout
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   rr_ptr_r;
    logic [IW-1:0]   gnt_idx_r;
    logic [IW-1:0]   lock_owner_r;
    logic            lock_valid_r;
    logic            abort_r;
    logic [IW-1:0]   sel_idx_s;
    logic            sel_valid_s;
    logic            tmo_hit_s;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 2) begin : g_bad_params
        $error("uart_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 2");
    end

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        logic [IW:0] sum;
        sum = {1'b0, base} + (IW+1)'(off);
        if (sum >= (IW+1)'(NUM_REQ)) begin
            sum = sum - (IW+1)'(NUM_REQ);
        end else begin
            sum = sum;
        end
        return sum[IW-1:0];
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Winner selection: locked owner only, else first requester at or after rr pointer.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = '0;
        if (lock_valid_r) begin
            sel_valid_s = i_req_request[lock_owner_r];
            sel_idx_s   = lock_owner_r;
        end else begin
            // Walk from the farthest offset down so the nearest requester is written last.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                sel_idx_s   = i_req_request[wrap_add(rr_ptr_r, k)] ? wrap_add(rr_ptr_r, k) : sel_idx_s;
                sel_valid_s = sel_valid_s | i_req_request[wrap_add(rr_ptr_r, k)];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] tmo_cnt_r;
    logic          timeout_r;

    assign tmo_hit_s = (state_r == ST_BUSY) && (tmo_cnt_r == TW'(TIMEOUT - 1));
    assign o_timeout = timeout_r;

    // BUSY cycle counter; IDLE always precedes BUSY, so entry sees it cleared.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tmo_cnt_r <= '0;
        end else if (state_r == ST_BUSY) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
        end else begin
            tmo_cnt_r <= '0;
        end
    end

    // Sticky abort flag; a UART ready on the terminal cycle is a normal completion.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            timeout_r <= 1'b0;
        end else if (tmo_hit_s && !i_uart_ready) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Arbitration FSM with registered UART and requester-side outputs.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_r        <= ST_IDLE;
            rr_ptr_r       <= '0;
            gnt_idx_r      <= '0;
            lock_owner_r   <= '0;
            lock_valid_r   <= 1'b0;
            abort_r        <= 1'b0;
            o_req_rdata    <= 32'h0000_0000;
            o_req_ready    <= '0;
            o_grant        <= '0;
            o_uart_request <= 1'b0;
            o_uart_rw      <= 1'b0;
            o_uart_address <= 2'b00;
            o_uart_wdata   <= 32'h0000_0000;
        end else begin
            o_req_ready <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (sel_valid_s) begin
                        gnt_idx_r      <= sel_idx_s;
                        o_uart_request <= 1'b1;
                        o_uart_rw      <= i_req_rw[sel_idx_s];
                        o_uart_address <= i_req_address[sel_idx_s];
                        o_uart_wdata   <= i_req_wdata[sel_idx_s];
                        o_grant        <= onehot(sel_idx_s);
                        state_r        <= ST_BUSY;
                    end else if (lock_valid_r && !i_req_lock[lock_owner_r]) begin
                        // Idle owner gave up its lock: reopen arbitration past it.
                        lock_valid_r <= 1'b0;
                        rr_ptr_r     <= wrap_add(lock_owner_r, 1);
                        o_grant      <= '0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (i_uart_ready) begin
                        o_req_rdata    <= i_uart_rdata;
                        o_req_ready    <= onehot(gnt_idx_r);
                        o_uart_request <= 1'b0;
                        abort_r        <= 1'b0;
                        state_r        <= ST_RELEASE;
                    end else if (tmo_hit_s) begin
                        o_req_rdata    <= 32'hFFFF_FFFF;
                        o_req_ready    <= onehot(gnt_idx_r);
                        o_uart_request <= 1'b0;
                        lock_valid_r   <= 1'b0;
                        abort_r        <= 1'b1;
                        state_r        <= ST_RELEASE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_RELEASE: begin
                    if (i_req_lock[gnt_idx_r] && !abort_r) begin
                        lock_valid_r <= 1'b1;
                        lock_owner_r <= gnt_idx_r;
                    end else begin
                        lock_valid_r <= 1'b0;
                        rr_ptr_r     <= wrap_add(gnt_idx_r, 1);
                        o_grant      <= '0;
                    end
                    abort_r <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r        <= ST_IDLE;
                    o_uart_request <= 1'b0;
                    o_grant        <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_arbiter.sv
// tb_uart_arbiter: table-driven directed bench for uart_arbiter with two requesters.
// Hand-written sequences cover lock hold, back-to-back, reset and BUSY-timeout corners.
module tb_uart_arbiter;

    localparam int N = 2;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_request;
    logic [N-1:0]      req_rw;
    logic [N-1:0][1:0] req_address;
    logic [N-1:0][31:0] req_wdata;
    logic [N-1:0]      req_lock;
    logic [31:0]       req_rdata;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      grant;
    logic              uart_request;
    logic              uart_rw;
    logic [1:0]        uart_address;
    logic [31:0]       uart_wdata;
    logic [31:0]       uart_rdata;
    logic              uart_ready;
    logic              timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    uart_arbiter #(.NUM_REQ(N), .TIMEOUT(16)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_req_request  (req_request),
        .i_req_rw       (req_rw),
        .i_req_address  (req_address),
        .i_req_wdata    (req_wdata),
        .i_req_lock     (req_lock),
        .o_req_rdata    (req_rdata),
        .o_req_ready    (req_ready),
        .o_grant        (grant),
        .o_uart_request (uart_request),
        .o_uart_rw      (uart_rw),
        .o_uart_address (uart_address),
        .o_uart_wdata   (uart_wdata),
        .i_uart_rdata   (uart_rdata),
        .i_uart_ready   (uart_ready),
        .o_timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  rw;
        logic [1:0]  lock;
        logic [1:0]  a0;
        logic [1:0]  a1;
        logic [31:0] w0;
        logic [31:0] w1;
        int          dly;
        logic [31:0] rd;
        int          elat;
        int          eg;
        logic        erw;
        logic [1:0]  ea;
        logic [31:0] ew;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] oh(input int g);
        return 32'd1 << g;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) chk("ready_idle_low", 32'(req_ready), 32'd0);
        end while (!uart_request && n < 20);
        chk("uart_req_seen", 32'(uart_request), 32'd1);
    endtask

    task automatic finish_txn(input int g, input int dly, input logic [31:0] rd);
        repeat (dly) step();
        chk("busy_hold_req", 32'(uart_request), 32'd1);
        chk("busy_no_ready", 32'(req_ready), 32'd0);
        uart_ready = 1'b1;
        uart_rdata = rd;
        step();
        uart_ready = 1'b0;
        uart_rdata = 32'hDEAD_BEEF;
        chk("ready_pulse", 32'(req_ready), oh(g));
        chk("rdata", req_rdata, rd);
        chk("uart_req_drop", 32'(uart_request), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int r1;
        int r2;
        int hi;

        //           req    rw     lock   a0    a1    w0             w1             dly rd             elat eg erw   ea    ew
        vecs[0] = '{2'b01, 2'b01, 2'b00, 2'd0, 2'd0, 32'h0000_0041, 32'h0000_0000, 4, 32'h0000_000F, 1, 0, 1'b1, 2'd0, 32'h0000_0041};
        vecs[1] = '{2'b10, 2'b00, 2'b00, 2'd0, 2'd2, 32'h0000_0000, 32'h0000_0000, 1, 32'h0000_005A, 2, 1, 1'b0, 2'd2, 32'h0000_0000};
        vecs[2] = '{2'b11, 2'b00, 2'b00, 2'd1, 2'd3, 32'h0000_0100, 32'h0000_0200, 0, 32'h0000_0011, 2, 0, 1'b0, 2'd1, 32'h0000_0100};
        vecs[3] = '{2'b11, 2'b00, 2'b00, 2'd1, 2'd3, 32'h0000_0100, 32'h0000_0200, 2, 32'h0000_0022, 2, 1, 1'b0, 2'd3, 32'h0000_0200};
        vecs[4] = '{2'b11, 2'b00, 2'b00, 2'd1, 2'd3, 32'h0000_0100, 32'h0000_0200, 0, 32'h0000_0033, 2, 0, 1'b0, 2'd1, 32'h0000_0100};
        vecs[5] = '{2'b11, 2'b00, 2'b00, 2'd1, 2'd3, 32'h0000_0100, 32'h0000_0200, 3, 32'h0000_0044, 2, 1, 1'b0, 2'd3, 32'h0000_0200};
        vecs[6] = '{2'b11, 2'b01, 2'b01, 2'd0, 2'd1, 32'h0000_00A1, 32'h0000_0000, 0, 32'h0000_00E1, 2, 0, 1'b1, 2'd0, 32'h0000_00A1};
        vecs[7] = '{2'b11, 2'b01, 2'b01, 2'd0, 2'd1, 32'h0000_00A2, 32'h0000_0000, 1, 32'h0000_00E2, 2, 0, 1'b1, 2'd0, 32'h0000_00A2};
        vecs[8] = '{2'b11, 2'b01, 2'b01, 2'd0, 2'd1, 32'h0000_00A3, 32'h0000_0000, 0, 32'h0000_00E3, 2, 0, 1'b1, 2'd0, 32'h0000_00A3};
        vecs[9] = '{2'b10, 2'b00, 2'b00, 2'd0, 2'd1, 32'h0000_0000, 32'h0000_0000, 2, 32'h0000_0077, 2, 1, 1'b0, 2'd1, 32'h0000_0000};

        rst         = 1'b0;
        req_request = '0;
        req_rw      = '0;
        req_address = '0;
        req_wdata   = '0;
        req_lock    = '0;
        uart_rdata  = 32'h0;
        uart_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_uart_req", 32'(uart_request), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rdata", req_rdata, 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst = 1'b1;
        step();

        // UART ready while idle must be ignored.
        uart_ready = 1'b1;
        uart_rdata = 32'h0000_0099;
        step();
        uart_ready = 1'b0;
        chk("idle_ready_ignored", 32'(req_ready), 32'd0);
        chk("idle_rdata_kept", req_rdata, 32'd0);
        chk("idle_no_uart_req", 32'(uart_request), 32'd0);

        for (int i = 0; i < 10; i++) begin
            req_request    = vecs[i].req;
            req_rw         = vecs[i].rw;
            req_lock       = vecs[i].lock;
            req_address[0] = vecs[i].a0;
            req_address[1] = vecs[i].a1;
            req_wdata[0]   = vecs[i].w0;
            req_wdata[1]   = vecs[i].w1;
            wait_req(n);
            chk("latency", n, vecs[i].elat);
            chk("grant", 32'(grant), oh(vecs[i].eg));
            chk("uart_rw", 32'(uart_rw), 32'(vecs[i].erw));
            chk("uart_addr", 32'(uart_address), 32'(vecs[i].ea));
            chk("uart_wdata", uart_wdata, vecs[i].ew);
            finish_txn(vecs[i].eg, vecs[i].dly, vecs[i].rd);
        end

        // Locked owner idle: others wait until the lock is dropped.
        req_request    = 2'b01;
        req_rw         = 2'b01;
        req_lock       = 2'b01;
        req_wdata[0]   = 32'h0000_00C0;
        wait_req(n);
        chk("lk_grant", 32'(grant), 32'd1);
        finish_txn(0, 1, 32'h0000_00C1);
        req_request    = 2'b10;
        req_rw         = 2'b00;
        req_address[1] = 2'd2;
        hi = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (uart_request) hi++;
        end
        chk("lk_blocked", hi, 0);
        chk("lk_grant_held", 32'(grant), 32'd1);
        req_lock = 2'b00;
        step();
        chk("lk_release_grant", 32'(grant), 32'd0);
        chk("lk_release_req", 32'(uart_request), 32'd0);
        step();
        chk("lk_next_req", 32'(uart_request), 32'd1);
        chk("lk_next_grant", 32'(grant), 32'd2);
        finish_txn(1, 0, 32'h0000_00D1);

        // Back-to-back from one requester with an immediate UART.
        req_request = 2'b01;
        req_rw      = 2'b01;
        wait_req(n);
        r1 = cyc;
        finish_txn(0, 0, 32'h0000_00B1);
        wait_req(n);
        r2 = cyc;
        chk("b2b_period", r2 - r1, 3);
        finish_txn(0, 0, 32'h0000_00B2);

        // Asynchronous reset in BUSY.
        req_request    = 2'b10;
        req_rw         = 2'b00;
        req_address[0] = 2'd3;
        req_address[1] = 2'd2;
        wait_req(n);
        chk("rb_grant", 32'(grant), 32'd2);
        step();
        step();
        #2;
        rst        = 1'b0;
        uart_ready = 1'b1;
        #1;
        chk("rb_grant_clr", 32'(grant), 32'd0);
        chk("rb_uart_req_clr", 32'(uart_request), 32'd0);
        chk("rb_addr_clr", 32'(uart_address), 32'd0);
        chk("rb_rdata_clr", req_rdata, 32'd0);
        step();
        chk("rb_no_ready", 32'(req_ready), 32'd0);
        rst         = 1'b1;
        uart_ready  = 1'b0;
        req_request = 2'b11;
        wait_req(n);
        chk("rb_fresh_grant", 32'(grant), 32'd1);
        finish_txn(0, 0, 32'h0000_005E);

        req_request = 2'b10;
        wait_req(n);
        chk("slow_grant", 32'(grant), 32'd2);
`ifdef UART_ARB_TIMEOUT_EN
        n = 0;
        do begin
            step();
            n++;
        end while (!req_ready && n < 40);
        chk("tmo_busy_cycles", n, 16);
        chk("tmo_ready", 32'(req_ready), 32'd2);
        chk("tmo_rdata", req_rdata, 32'hFFFF_FFFF);
        chk("tmo_flag", 32'(timeout), 32'd1);
        chk("tmo_uart_req", 32'(uart_request), 32'd0);
        req_request = 2'b00;
        repeat (3) step();
        chk("tmo_sticky", 32'(timeout), 32'd1);
`else
        repeat (40) step();
        chk("slow_still_req", 32'(uart_request), 32'd1);
        chk("slow_no_ready", 32'(req_ready), 32'd0);
        chk("slow_no_timeout", 32'(timeout), 32'd0);
        finish_txn(1, 0, 32'h0000_003C);
        req_request = 2'b00;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
